// File: rtl/button_ctrl_if.sv
// Button controller bundle: raw button levels in, press pulses / mode / debug levels out.
interface button_ctrl_if;
    logic [3:0] pButton;
    logic       pMode;
    logic [3:0] vButton;
    logic [1:0] clk_mode;
    logic [4:0] pressed;

    modport master (output pButton, pMode, input vButton, clk_mode, pressed);
    modport slave  (input pButton, pMode, output vButton, clk_mode, pressed);
endinterface

// File: rtl/button_ctrl.sv
// button_ctrl: synchronizes and debounces four buttons plus a mode button,
// emits one-cycle press pulses (with auto-repeat on buttons 0-2) and runs a
// four-state mode machine that falls back to mode 0 after an idle period.
module button_ctrl #(
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_PERIOD = 8,
    parameter int unsigned IDLE_TIMEOUT  = 100
) (
    input  logic         mclk,
    input  logic         rst,
    button_ctrl_if.slave bus
);
    localparam int NIN  = 5;  // {mode, button[3:0]}
    localparam int NREP = 3;  // buttons that auto-repeat
    localparam logic [31:0] DB_LIM = 32'(DB_CYCLES);
    localparam logic [31:0] RD_LIM = 32'(REPEAT_DELAY);
    // Reloading to this value after a repeat makes the next repeat land
    // REPEAT_PERIOD cycles later while the counter never exceeds RD_LIM.
    localparam logic [31:0] RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    // The cycle in which the timer would reach IDLE_TIMEOUT is the one that
    // drops the mode, so exactly IDLE_TIMEOUT quiet cycles leave a mode.
    localparam logic [31:0] IT_LIM = 32'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {MODE0 = 2'd0, MODE1 = 2'd1, MODE2 = 2'd2, MODE3 = 2'd3} mode_e;

    logic [NIN-1:0]        raw;
    logic [NIN-1:0]        sync1_q, sync2_q;
    logic [NIN-1:0]        db_q, db_d, prev_q, rise;
    logic [NIN-1:0][31:0]  dbcnt_q, dbcnt_d;
    logic [NREP-1:0][31:0] hold_q, hold_d;
    logic [NREP-1:0]       rep;
    logic [3:0]            vbtn_q, vbtn_d;
    mode_e                 mode_q, mode_d;
    logic [31:0]           idle_q, idle_d;
    logic                  mode_edge;

    assign raw = {bus.pMode, bus.pButton};

    // Two-flop synchronizers on every raw input
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count disagreeing samples, accept the new level at DB_CYCLES
    always_comb begin
        db_d    = db_q;
        dbcnt_d = dbcnt_q;
        for (int i = 0; i < NIN; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                dbcnt_d[i] = '0;
            end else if (dbcnt_q[i] >= DB_LIM) begin
                db_d[i]    = sync2_q[i];
                dbcnt_d[i] = '0;
            end else begin
                dbcnt_d[i] = dbcnt_q[i] + 32'd1;
            end
        end
    end

    assign rise = db_q & ~prev_q;

    // Hold counters; keyed on the next debounced level so a release cycle never repeats
    always_comb begin
        hold_d = hold_q;
        rep    = '0;
        for (int i = 0; i < NREP; i++) begin
            if (!db_d[i]) begin
                hold_d[i] = '0;
            end else if (rise[i]) begin
                hold_d[i] = 32'd1;
            end else if (hold_q[i] >= RD_LIM) begin
                rep[i]    = 1'b1;
                hold_d[i] = RELOAD;
            end else if (hold_q[i] != '0) begin
                hold_d[i] = hold_q[i] + 32'd1;
            end
        end
    end

    assign vbtn_d    = {rise[3], rise[2:0] | rep};
    assign mode_edge = rise[4];

    // Mode next-state and idle timer; a mode edge beats a simultaneous timeout
    always_comb begin
        mode_d = mode_q;
        idle_d = idle_q;
        if (mode_edge) begin
            idle_d = '0;
            case (mode_q)
                MODE0:   mode_d = MODE1;
                MODE1:   mode_d = MODE2;
                MODE2:   mode_d = MODE3;
                default: mode_d = MODE0;
            endcase
        end else if ((|vbtn_d) || (mode_q == MODE0)) begin
            idle_d = '0;
        end else if (idle_q >= IT_LIM) begin
            mode_d = MODE0;
            idle_d = '0;
        end else begin
            idle_d = idle_q + 32'd1;
        end
    end

    // State registers for debounce, pulses, hold counters and mode
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            db_q    <= '0;
            dbcnt_q <= '0;
            prev_q  <= '0;
            hold_q  <= '0;
            vbtn_q  <= '0;
            mode_q  <= MODE0;
            idle_q  <= '0;
        end else begin
            db_q    <= db_d;
            dbcnt_q <= dbcnt_d;
            prev_q  <= db_q;
            hold_q  <= hold_d;
            vbtn_q  <= vbtn_d;
            mode_q  <= mode_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.vButton  = vbtn_q;
    assign bus.clk_mode = mode_q;
    assign bus.pressed  = db_q;
endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a timing-rule model.
module tb_button_ctrl;
    localparam int DB = 4, RD = 20, RP = 8, IT = 100;

    logic mclk = 1'b0;
    logic rst  = 1'b0;
    button_ctrl_if bus();
    button_ctrl #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .IDLE_TIMEOUT(IT))
        dut (.mclk(mclk), .rst(rst), .bus(bus));

    always #5 mclk = ~mclk;

    int n_tests = 0, n_fail = 0, ecnt = 0;
    int pl[4][$];
    int mlog_t[$], mlog_v[$];
    int first_pr0 = -1, last_mode_seen = 0;
    logic [4:0] pr_or = '0;
    int s3_exp[6] = '{7, 27, 35, 43, 51, 59};
    int s5_t[6]   = '{7, 27, 47, 67, 107, 207};
    int s5_v[6]   = '{1, 2, 3, 0, 1, 0};

    // model: sampled raw delay line, disagreement run, debounced level, rise edge times
    logic [4:0] m_d1, m_d2, m_db;
    int m_run[5], m_rise[5], m_mode, m_last;
    logic [3:0] e_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_db = '0; e_v = '0;
        for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_rise[i] = -1000; end
        m_mode = 0; m_last = 0;
    endfunction

    // t = index of this edge since reset release; raw = input levels sampled at it
    function automatic void model_step(input int t, input logic [4:0] raw);
        logic [4:0] use_v, db_b;
        use_v = m_d2; m_d2 = m_d1; m_d1 = raw;
        db_b = m_db;
        for (int i = 0; i < 5; i++) begin
            if (use_v[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB + 1) begin
                    m_db[i] = use_v[i]; m_run[i] = 0;
                    if (use_v[i]) m_rise[i] = t;
                end
            end else m_run[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            e_v[i] = db_b[i] && (m_rise[i] == t - 1);
            if (i < 3 && m_db[i] && (t - m_rise[i] - 1 >= RD) && ((t - m_rise[i] - 1 - RD) % RP == 0))
                e_v[i] = 1'b1;
        end
        if (db_b[4] && m_rise[4] == t - 1) begin m_mode = (m_mode + 1) % 4; m_last = t; end
        else if (e_v != 0) m_last = t;
        else if (m_mode != 0 && t - m_last >= IT) m_mode = 0;
    endfunction

    // Per-cycle compare against the model, 1 time unit after each rising edge
    initial begin
        int t;
        model_reset();
        forever begin
            @(posedge mclk);
            if (!rst) begin
                model_reset();
                #1;
                chk("rst_vButton", 32'(bus.vButton), 0);
                chk("rst_clk_mode", 32'(bus.clk_mode), 0);
                chk("rst_pressed", 32'(bus.pressed), 0);
            end else begin
                t = ecnt;
                model_step(t, {bus.pMode, bus.pButton});
                ecnt = ecnt + 1;
                #1;
                chk("vButton", 32'(bus.vButton), 32'(e_v));
                chk("clk_mode", 32'(bus.clk_mode), 32'(m_mode));
                chk("pressed", 32'(bus.pressed), 32'(m_db));
                for (int i = 0; i < 4; i++) if (bus.vButton[i] === 1'b1) pl[i].push_back(t);
                if (bus.pressed[0] === 1'b1 && first_pr0 < 0) first_pr0 = t;
                pr_or = pr_or | bus.pressed;
                if (int'(bus.clk_mode) != last_mode_seen) begin
                    mlog_t.push_back(t); mlog_v.push_back(int'(bus.clk_mode));
                    last_mode_seen = int'(bus.clk_mode);
                end
            end
        end
    end

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        chk("async_rst_vButton", 32'(bus.vButton), 0);
        chk("async_rst_clk_mode", 32'(bus.clk_mode), 0);
        chk("async_rst_pressed", 32'(bus.pressed), 0);
        repeat (3) @(negedge mclk);
        for (int i = 0; i < 4; i++) pl[i].delete();
        mlog_t.delete(); mlog_v.delete();
        first_pr0 = -1; pr_or = '0; last_mode_seen = 0; ecnt = 0;
        rst = 1'b1;
    endtask

    // Return at the falling edge just before edge k, so edge k samples what is driven next
    task automatic at(input int k);
        int g = 0;
        while (ecnt < k && g < 5000) begin @(negedge mclk); g++; end
        if (ecnt < k) chk("wait_timeout", 32'(ecnt), 32'(k));
    endtask

    initial begin
        int cnt[5];
        logic lvl[5];
        bus.pButton = '0; bus.pMode = 1'b0;
        @(negedge mclk);
        reset_pulse();

        // clean press of button 0
        at(10); bus.pButton[0] = 1'b1; at(20); bus.pButton[0] = 1'b0; at(40);
        chk("s1_count", 32'(pl[0].size()), 1);
        chk("s1_pulse_cycle", 32'(pl[0].size() > 0 ? pl[0][0] : -1), 17);
        chk("s1_pressed_cycle", 32'(first_pr0), 16);

        // 3-cycle glitch on button 1
        reset_pulse();
        at(5); bus.pButton[1] = 1'b1; at(8); bus.pButton[1] = 1'b0; at(30);
        chk("s2_pulses", 32'(pl[1].size()), 0);
        chk("s2_pressed", 32'(pr_or[1]), 0);

        // button 2 held 60 cycles: auto-repeat
        reset_pulse();
        at(0); bus.pButton[2] = 1'b1; at(60); bus.pButton[2] = 1'b0; at(110);
        chk("s3_count", 32'(pl[2].size()), 6);
        for (int i = 0; i < 6; i++)
            chk("s3_pulse_cycle", 32'(pl[2].size() > i ? pl[2][i] : -1), 32'(s3_exp[i]));

        // setampm held 60 cycles: single pulse
        reset_pulse();
        at(0); bus.pButton[3] = 1'b1; at(60); bus.pButton[3] = 1'b0; at(90);
        chk("s4_count", 32'(pl[3].size()), 1);

        // mode presses then idle timeout
        reset_pulse();
        for (int p = 0; p < 4; p++) begin
            at(p * 20); bus.pMode = 1'b1; at(p * 20 + 8); bus.pMode = 1'b0;
        end
        at(100); bus.pMode = 1'b1; at(108); bus.pMode = 1'b0; at(250);
        chk("s5_changes", 32'(mlog_t.size()), 6);
        for (int i = 0; i < 6; i++) begin
            chk("s5_mode_cycle", 32'(mlog_t.size() > i ? mlog_t[i] : -1), 32'(s5_t[i]));
            chk("s5_mode_value", 32'(mlog_v.size() > i ? mlog_v[i] : -1), 32'(s5_v[i]));
        end

        // reset mid-repeat while button 0 stays held
        reset_pulse();
        at(0); bus.pButton[0] = 1'b1; at(35);
        @(posedge mclk); #2;
        chk("s6_pulse_before_rst", 32'(bus.vButton[0]), 1);
        reset_pulse();
        at(20);
        chk("s6_count", 32'(pl[0].size()), 1);
        chk("s6_first_after_rst", 32'(pl[0].size() > 0 ? pl[0][0] : -1), 7);
        bus.pButton[0] = 1'b0;

        // randomized phase: glitches and holds on all five inputs
        reset_pulse();
        for (int j = 0; j < 5; j++) begin cnt[j] = 0; lvl[j] = 1'b0; end
        for (int c = 0; c < 4000; c++) begin
            @(negedge mclk);
            if (c == 2000) begin #($urandom_range(1, 4)); reset_pulse(); end
            for (int j = 0; j < 5; j++) begin
                if (cnt[j] == 0) begin
                    lvl[j] = ~lvl[j];
                    if ($urandom_range(0, 3) == 0) cnt[j] = $urandom_range(1, 4);
                    else if (lvl[j]) cnt[j] = $urandom_range(5, 60);
                    else cnt[j] = $urandom_range(5, 200);
                end
                cnt[j]--;
                if (j < 4) bus.pButton[j] = lvl[j]; else bus.pMode = lvl[j];
            end
        end
        repeat (5) @(negedge mclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end
endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4, sets the number of consecutive stable synchronized samples needed to accept a level change.
REQ-002 Parameter REPEAT_DELAY, default 20, sets the mclk cycles a button must be held before its first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 8, sets the mclk cycles between later auto-repeat pulses.
REQ-004 Parameter IDLE_TIMEOUT, default 100, sets the mclk cycles with no accepted press before a non-default mode returns to 0.
REQ-005 mclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 pButton  input  4  raw, asynchronous button levels; bits 0/1/2 = button1/2/3, bit 3 = setampm; high = pressed.
REQ-008 pMode  input  1  raw, asynchronous mode-button level; high = pressed.
REQ-009 vButton  output  4  one-mclk press pulses, bit mapping as pButton.
REQ-010 clk_mode  output  2  0 = default, 1 = set time, 2 = set alarm, 3 = set date.
REQ-011 pressed  output  5  debounced levels, {mode, pButton[3:0]}, for debug LEDs.

Function
REQ-012 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Each input SHALL have its own debounce counter, at least 32 bits wide:
- counter cleared whenever the synchronized value equals the debounced level;
- counter incremented while the two differ;
- when it reaches DB_CYCLES, the debounced level takes the synchronized value and the counter clears.
REQ-014 A glitch shorter than DB_CYCLES cycles SHALL NOT change the debounced level and SHALL NOT produce any output.
REQ-015 vButton[i] SHALL be high for exactly one mclk cycle, in the cycle after debounced level i rises.
REQ-016 Latency from a clean raw edge to vButton high SHALL be DB_CYCLES+3 mclk cycles.
REQ-017 Buttons 0-2 SHALL auto-repeat while their debounced level stays high:
- a hold counter starts at the initial pulse;
- a repeat pulse occurs REPEAT_DELAY cycles after the initial pulse;
- further repeat pulses follow every REPEAT_PERIOD cycles.
REQ-018 Releasing a button (debounced level falls) SHALL clear its hold counter immediately; no repeat pulse may occur in or after the release cycle.
REQ-019 Button 3 (setampm) SHALL NOT auto-repeat; it produces one pulse per press.
REQ-020 Buttons SHALL be independent; several vButton bits may be high in the same cycle.
REQ-021 Mode state machine: states MODE0..MODE3, encoded as clk_mode 0..3.
- On a debounced rising edge of pMode: 0->1->2->3->0.
- The state register updates in the cycle after the debounced level rises.
- pMode does not auto-repeat.
REQ-022 Idle timer, at least 32 bits wide:
- cleared on any vButton pulse (initial or repeat) or mode edge;
- otherwise increments while clk_mode != 0 and holds at 0 while clk_mode == 0.
REQ-023 When the idle timer reaches IDLE_TIMEOUT, clk_mode SHALL go to 0 on the next edge and the timer SHALL clear.
REQ-024 If a mode edge and the timeout occur in the same cycle, the mode edge SHALL win and clk_mode advances normally.
REQ-025 vButton pulses SHALL be generated in every mode, including mode 0; the consuming block decides how to use them.
REQ-026 Counters SHALL saturate or clear; none may wrap in a way that produces a spurious pulse, even if a button is held indefinitely.

Reset
REQ-027 While rst is low, the block SHALL asynchronously force:
- vButton = 0, clk_mode = 0, pressed = 0;
- all synchronizer flops, debounce counters, hold counters and the idle timer to 0.
REQ-028 Reset released while a button is physically held SHALL produce a pulse only after DB_CYCLES+3 cycles, exactly as for a fresh press.
REQ-029 Reset asserted mid-press or mid-repeat SHALL abort all activity immediately; no pulse may occur in the cycle reset is released.

Verification (defaults: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, IDLE_TIMEOUT=100)
REQ-030 Clean press of pButton[0] at cycle 10, held 10 cycles -> single vButton[0] pulse at cycle 17, pressed[0] high from cycle 16.
REQ-031 pButton[1] high for 3 cycles then low -> no vButton activity and pressed stays 0.
REQ-032 pButton[2] held 60 cycles starting at cycle 0 -> pulses at cycles 7, 27, 35, 43, 51, 59; none after release.
REQ-033 pButton[3] held 60 cycles -> exactly one vButton[3] pulse.
REQ-034 Four pMode presses, spaced 20 cycles apart -> clk_mode goes 1, 2, 3, 0; with one press then no activity, clk_mode returns to 0 exactly 100 cycles after entering mode 1.
REQ-035 rst pulsed low during a held pButton[0] repeat sequence -> outputs go to 0 asynchronously; after release, next pulse occurs 7 cycles later.
